// File: rtl/route_ctrl.sv
// Per-input-port route controller: fetches flits from the input buffer, XY-routes the
// head flit, holds the switch-allocator grant for the packet and forwards flits.
module route_ctrl #(
  parameter int MY_X = 2,
  parameter int MY_Y = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        buf_empty_i,
  input  logic        buf_valid_i,
  input  logic [15:0] buf_data_i,
  output logic        buf_read_o,
  output logic [4:0]  out_req_o,
  input  logic [4:0]  out_grant_i,
  output logic [15:0] flit_o,
  output logic        flit_valid_o,
  input  logic        out_ready_i,
  output logic        err_o
);

  localparam logic [3:0] MY_X4 = 4'(MY_X);
  localparam logic [3:0] MY_Y4 = 4'(MY_Y);

  localparam logic [4:0] PORT_LOCAL = 5'b00001;
  localparam logic [4:0] PORT_NORTH = 5'b00010;
  localparam logic [4:0] PORT_EAST  = 5'b00100;
  localparam logic [4:0] PORT_SOUTH = 5'b01000;
  localparam logic [4:0] PORT_WEST  = 5'b10000;

  typedef enum logic [1:0] {IDLE, ROUTE, WAIT_GNT, XFER} state_t;

  state_t      state_reg, state_next;
  logic        hold_v_reg, hold_v_next;
  logic [15:0] hold_q_reg;
  logic        rd_pend_reg;
  logic [4:0]  port_reg, port_next;
  logic [4:0]  route_port;
  logic [3:0]  dest_x, dest_y;

  assign dest_x = hold_q_reg[7:4];
  assign dest_y = hold_q_reg[3:0];

  // X is resolved before Y so packets never turn from a Y hop back into X.
  always_comb begin
    route_port = PORT_LOCAL;
    if (dest_x > MY_X4)      route_port = PORT_EAST;
    else if (dest_x < MY_X4) route_port = PORT_WEST;
    else if (dest_y > MY_Y4) route_port = PORT_NORTH;
    else if (dest_y < MY_Y4) route_port = PORT_SOUTH;
  end

  always_comb begin
    state_next   = state_reg;
    hold_v_next  = hold_v_reg;
    port_next    = port_reg;
    err_o        = 1'b0;
    out_req_o    = 5'b00000;
    flit_valid_o = 1'b0;
    flit_o       = 16'h0000;
    // Reset gates the strobe so the buffer sees no read while the controller is held.
    buf_read_o   = !reset && !buf_empty_i && !rd_pend_reg && !hold_v_reg
                   && (state_reg != WAIT_GNT);
    case (state_reg)
      IDLE: begin
        if (hold_v_reg) begin
          if (hold_q_reg[15]) begin
            state_next = ROUTE;
          end else begin
            hold_v_next = 1'b0;
            err_o       = 1'b1;
          end
        end
      end
      ROUTE: begin
        port_next  = route_port;
        state_next = WAIT_GNT;
      end
      WAIT_GNT: begin
        out_req_o = port_reg;
        if ((out_grant_i & port_reg) != 5'b00000) state_next = XFER;
      end
      XFER: begin
        out_req_o    = port_reg;
        flit_valid_o = hold_v_reg;
        flit_o       = hold_v_reg ? hold_q_reg : 16'h0000;
        if (hold_v_reg && out_ready_i) begin
          hold_v_next = 1'b0;
          if (hold_q_reg[14]) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      hold_v_reg  <= 1'b0;
      hold_q_reg  <= 16'h0000;
      rd_pend_reg <= 1'b0;
      port_reg    <= 5'b00000;
    end else begin
      state_reg <= state_next;
      port_reg  <= port_next;
      // Returned data only lands while the holding register is empty, so it never
      // collides with a consume in the same cycle.
      if (buf_valid_i) begin
        hold_v_reg <= 1'b1;
        hold_q_reg <= buf_data_i;
      end else begin
        hold_v_reg <= hold_v_next;
      end
      if (buf_read_o)       rd_pend_reg <= 1'b1;
      else if (buf_valid_i) rd_pend_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_route_ctrl.sv
// Directed bench for route_ctrl at router (2,2) with a one-cycle-latency buffer model
// and an in-order scoreboard of flits expected at the crossbar.
module tb_route_ctrl;

  logic        clk;
  logic        reset;
  logic        buf_empty_i;
  logic        buf_valid_i;
  logic [15:0] buf_data_i;
  logic        buf_read_o;
  logic [4:0]  out_req_o;
  logic [4:0]  out_grant_i;
  logic [15:0] flit_o;
  logic        flit_valid_o;
  logic        out_ready_i;
  logic        err_o;

  route_ctrl #(.MY_X(2), .MY_Y(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .buf_empty_i  (buf_empty_i),
    .buf_valid_i  (buf_valid_i),
    .buf_data_i   (buf_data_i),
    .buf_read_o   (buf_read_o),
    .out_req_o    (out_req_o),
    .out_grant_i  (out_grant_i),
    .flit_o       (flit_o),
    .flit_valid_o (flit_valid_o),
    .out_ready_i  (out_ready_i),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] fifo[$];
  logic [15:0] exp_q[$];
  logic        rd_seen;
  logic [15:0] rd_data;
  logic        tail_done;
  int          reads;
  int          checks;
  int          errors;
  logic [15:0] sw_head[5];
  logic [4:0]  sw_port[5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: record a crossbar handshake, advance, then play the buffer's part.
  task automatic cycle();
    logic [15:0] want;
    tail_done = 1'b0;
    if (!reset && flit_valid_o && out_ready_i) begin
      $display("flit delivered %h", flit_o);
      tail_done = flit_o[14];
      if (exp_q.size() == 0) begin
        check("extra_flit", {16'h0, flit_o}, 32'hffff_ffff);
      end else begin
        want = exp_q.pop_front();
        check("flit_order", {16'h0, flit_o}, {16'h0, want});
      end
    end
    @(posedge clk);
    #1;
    buf_valid_i = rd_seen;
    buf_data_i  = rd_seen ? rd_data : 16'h0000;
    buf_empty_i = (fifo.size() == 0);
    #1;
    rd_seen = buf_read_o;
    if (rd_seen) begin
      rd_data = fifo.pop_front();
      reads++;
    end
  endtask

  task automatic push(input logic [15:0] f, input logic deliver);
    fifo.push_back(f);
    if (deliver) exp_q.push_back(f);
  endtask

  task automatic wait_req(input string tag, input logic [4:0] exp);
    int n;
    n = 0;
    while (out_req_o == 5'b00000 && n < 12) begin
      cycle();
      n++;
    end
    check({tag, "_req"}, {27'h0, out_req_o}, {27'h0, exp});
  endtask

  task automatic drain(input string tag, input logic [4:0] grant);
    int   n;
    logic done;
    n = 0;
    done = 1'b0;
    out_grant_i = grant;
    out_ready_i = 1'b1;
    while (!done && n < 60) begin
      cycle();
      n++;
      if (tail_done) done = 1'b1;
    end
    check({tag, "_tail_done"}, {31'h0, done}, 32'h1);
    check({tag, "_req_drop"}, {27'h0, out_req_o}, 32'h0);
    check({tag, "_left"}, exp_q.size(), 32'h0);
    out_grant_i = 5'b00000;
    out_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   err_cnt;
    logic fv_seen;
    checks = 0; errors = 0; reads = 0;
    rd_seen = 1'b0; rd_data = 16'h0; tail_done = 1'b0;
    reset = 1'b1; buf_empty_i = 1'b1; buf_valid_i = 1'b0; buf_data_i = 16'h0;
    out_grant_i = 5'b00000; out_ready_i = 1'b0;
    sw_head[0] = 16'h8012; sw_port[0] = 5'b10000;
    sw_head[1] = 16'h8022; sw_port[1] = 5'b00001;
    sw_head[2] = 16'h8023; sw_port[2] = 5'b00010;
    sw_head[3] = 16'h8021; sw_port[3] = 5'b01000;
    sw_head[4] = 16'h8032; sw_port[4] = 5'b00100;

    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    check("rst_req", {27'h0, out_req_o}, 32'h0);
    check("rst_fv", {31'h0, flit_valid_o}, 32'h0);
    check("rst_err", {31'h0, err_o}, 32'h0);
    check("rst_flit", {16'h0, flit_o}, 32'h0);
    check("rst_read", {31'h0, buf_read_o}, 32'h0);

    // Head to (3,3) goes east; one read, held until granted.
    reads = 0;
    push(16'h8033, 1'b1);
    wait_req("east_head", 5'b00100);
    check("east_reads", reads, 32'h1);
    check("east_fv_wait", {31'h0, flit_valid_o}, 32'h0);
    out_grant_i = 5'b00100;
    out_ready_i = 1'b0;
    cycle();
    check("east_fv", {31'h0, flit_valid_o}, 32'h1);
    check("east_flit", {16'h0, flit_o}, 32'h8033);
    push(16'h4000, 1'b1);
    drain("east", 5'b00100);

    for (int i = 0; i < 5; i++) begin
      push(sw_head[i], 1'b1);
      push(16'h4000, 1'b1);
      wait_req($sformatf("sweep%0d", i), sw_port[i]);
      drain($sformatf("sweep%0d", i), sw_port[i]);
    end

    // Three-flit packet with the body flit stalled for four cycles.
    push(16'h8022, 1'b1);
    push(16'h0100, 1'b1);
    push(16'h4200, 1'b1);
    wait_req("stall", 5'b00001);
    out_grant_i = 5'b00001;
    out_ready_i = 1'b1;
    n = 0;
    while (!(flit_valid_o && flit_o == 16'h0100) && n < 20) begin
      cycle();
      n++;
    end
    out_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("stall_fv", {31'h0, flit_valid_o}, 32'h1);
      check("stall_flit", {16'h0, flit_o}, 32'h0100);
    end
    drain("stall", 5'b00001);

    // A grant for another port must not start the transfer.
    push(16'h8032, 1'b1);
    push(16'h4000, 1'b1);
    wait_req("wrong_gnt", 5'b00100);
    out_grant_i = 5'b00010;
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("wg_fv", {31'h0, flit_valid_o}, 32'h0);
      check("wg_read", {31'h0, buf_read_o}, 32'h0);
      check("wg_req", {27'h0, out_req_o}, 32'h04);
    end
    drain("wrong_gnt", 5'b00100);

    // Stray body flit in IDLE: dropped with a single error pulse.
    push(16'h0155, 1'b0);
    err_cnt = 0;
    fv_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (err_o) err_cnt++;
      if (flit_valid_o) fv_seen = 1'b1;
    end
    check("err_pulses", err_cnt, 32'h1);
    check("err_fv", {31'h0, fv_seen}, 32'h0);
    push(16'hC021, 1'b1);
    wait_req("after_err", 5'b01000);
    drain("after_err", 5'b01000);

    // Reset in the middle of a packet aborts it.
    push(16'h8023, 1'b1);
    push(16'h0100, 1'b1);
    push(16'h4200, 1'b1);
    wait_req("abort", 5'b00010);
    out_grant_i = 5'b00010;
    out_ready_i = 1'b1;
    n = 0;
    while (exp_q.size() > 2 && n < 20) begin
      cycle();
      n++;
    end
    check("abort_head_sent", exp_q.size(), 32'h2);
    reset = 1'b1;
    fifo.delete();
    exp_q.delete();
    rd_seen = 1'b0;
    cycle();
    check("abort_req", {27'h0, out_req_o}, 32'h0);
    check("abort_fv", {31'h0, flit_valid_o}, 32'h0);
    check("abort_read", {31'h0, buf_read_o}, 32'h0);
    reset = 1'b0;
    out_grant_i = 5'b00000;
    out_ready_i = 1'b0;
    cycle();
    check("abort_req_after", {27'h0, out_req_o}, 32'h0);
    push(16'hC022, 1'b1);
    wait_req("recover", 5'b00001);
    drain("recover", 5'b00001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
